// File: rtl/seg_scan_rx.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_rx
// Purpose  : Watches a scanned 6-digit 7-segment bus and rebuilds the shown
//            digits, decimal points and binary min/sec, one frame at a time.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_rx #(
    parameter int P_SETTLE  = 4,
    parameter int P_TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic [5:0]  o_digit_vld,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic        o_time_vld,
    output logic        o_frame_done,
    output logic        o_err,
    output logic        o_stale
);

    localparam int                    c_SETTLE_W    = $clog2(P_SETTLE + 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(P_SETTLE - 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_MAX  = c_SETTLE_W'(P_SETTLE);
    localparam logic [31:0]           c_TMO_LAST    = 32'(P_TIMEOUT - 1);
    localparam logic [31:0]           c_TMO_MAX     = 32'(P_TIMEOUT);

    typedef enum logic [0:0] {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_exp;
    logic [2:0]            w_exp_nxt;

    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [5:0]            r_enb;
    logic [5:0]            r_enb_prev;
    logic [c_SETTLE_W-1:0] r_settle;
    logic [31:0]           r_tmo;

    logic [23:0]           r_sh_dig;
    logic [5:0]            r_sh_dp;
    logic [5:0]            r_sh_vld;
    logic [23:0]           w_sh_dig_nxt;
    logic [5:0]            w_sh_dp_nxt;
    logic [5:0]            w_sh_vld_nxt;

    logic [5:0]            w_inv;
    logic                  w_onehot;
    logic                  w_settled;
    logic                  w_cap;
    logic                  w_perr;
    logic                  w_tmo_hit;
    logic [2:0]            w_idx;
    logic [3:0]            w_dig;
    logic                  w_dvld;
    logic                  w_derr;
    logic                  w_wr;
    logic                  w_sh_clr;
    logic                  w_commit;
    logic                  w_seq_err;
    logic                  w_err;
    logic [3:0]            w_d0;
    logic [3:0]            w_d1;
    logic [3:0]            w_d2;
    logic [3:0]            w_d3;
    logic [5:0]            w_sec;
    logic [5:0]            w_min;
    logic                  w_tvld;

    // Input stage and settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= 7'h00;
            r_dp       <= 1'b0;
            r_enb      <= 6'h3F;
            r_enb_prev <= 6'h3F;
            r_settle   <= '0;
        end else begin
            r_seg      <= i_seg;
            r_dp       <= i_seg_dp;
            r_enb      <= i_seg_enb;
            r_enb_prev <= r_enb;
            if (r_enb != r_enb_prev) begin
                r_settle <= '0;
            end else if (r_settle != c_SETTLE_MAX) begin
                r_settle <= r_settle + 1'b1;
            end
        end
    end

    // The counter passes c_SETTLE_LAST only once per pattern, so capture is single-shot
    assign w_inv     = ~r_enb;
    assign w_onehot  = (w_inv != 6'h00) && ((w_inv & (w_inv - 6'd1)) == 6'h00);
    assign w_settled = (r_enb == r_enb_prev) && (r_settle == c_SETTLE_LAST);
    assign w_cap     = w_settled && w_onehot;
    assign w_perr    = w_settled && !w_onehot && (r_enb != 6'h3F);
    assign w_tmo_hit = !w_cap && (r_tmo == c_TMO_LAST);

    always_comb begin
        w_idx = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (w_inv[k]) begin
                w_idx = 3'(k);
            end
        end
    end

    always_comb begin
        w_dvld = 1'b1;
        w_derr = 1'b0;
        case (r_seg)
            7'h7E:   w_dig = 4'd0;
            7'h30:   w_dig = 4'd1;
            7'h6D:   w_dig = 4'd2;
            7'h79:   w_dig = 4'd3;
            7'h33:   w_dig = 4'd4;
            7'h5B:   w_dig = 4'd5;
            7'h5F:   w_dig = 4'd6;
            7'h70:   w_dig = 4'd7;
            7'h7F:   w_dig = 4'd8;
            7'h73:   w_dig = 4'd9;
            7'h00: begin
                w_dig  = 4'hF;
                w_dvld = 1'b0;
            end
            default: begin
                w_dig  = 4'hE;
                w_dvld = 1'b0;
                w_derr = 1'b1;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SYNC;
            r_exp   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
        end
    end

    // FSM next-state; a bad or timed-out stream always falls back to SYNC
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_wr        = 1'b0;
        w_sh_clr    = 1'b0;
        w_commit    = 1'b0;
        w_seq_err   = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_cap && (w_idx == 3'd0)) begin
                    w_wr        = 1'b1;
                    w_exp_nxt   = 3'd1;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (w_cap) begin
                    if (w_idx == r_exp) begin
                        w_wr = 1'b1;
                        if (w_idx == 3'd5) begin
                            w_commit  = 1'b1;
                            w_exp_nxt = 3'd0;
                        end else begin
                            w_exp_nxt = r_exp + 3'd1;
                        end
                    end else begin
                        w_seq_err = 1'b1;
                        w_sh_clr  = 1'b1;
                        if (w_idx == 3'd0) begin
                            w_wr      = 1'b1;
                            w_exp_nxt = 3'd1;
                        end else begin
                            w_state_nxt = SYNC;
                        end
                    end
                end
            end
            default: w_state_nxt = SYNC;
        endcase
        if (w_perr || w_tmo_hit) begin
            w_state_nxt = SYNC;
            w_sh_clr    = 1'b1;
        end
    end

    assign w_err = w_perr || w_seq_err || (w_wr && w_derr);

    always_comb begin
        w_sh_dig_nxt = w_sh_clr ? 24'h000000 : r_sh_dig;
        w_sh_dp_nxt  = w_sh_clr ? 6'h00 : r_sh_dp;
        w_sh_vld_nxt = w_sh_clr ? 6'h00 : r_sh_vld;
        if (w_wr) begin
            w_sh_dig_nxt[{w_idx, 2'b00} +: 4] = w_dig;
            w_sh_dp_nxt[w_idx]                = r_dp;
            w_sh_vld_nxt[w_idx]               = w_dvld;
        end
    end

    // Commit uses the shadow including the slot-5 write happening this cycle
    assign w_d0   = w_sh_dig_nxt[3:0];
    assign w_d1   = w_sh_dig_nxt[7:4];
    assign w_d2   = w_sh_dig_nxt[11:8];
    assign w_d3   = w_sh_dig_nxt[15:12];
    assign w_sec  = {2'b00, w_d1} * 6'd10 + {2'b00, w_d0};
    assign w_min  = {2'b00, w_d3} * 6'd10 + {2'b00, w_d2};
    assign w_tvld = (&w_sh_vld_nxt[3:0]) && (w_d1 <= 4'd5) && (w_d3 <= 4'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo        <= 32'd0;
            r_sh_dig     <= 24'h000000;
            r_sh_dp      <= 6'h00;
            r_sh_vld     <= 6'h00;
            o_digits     <= 24'hFFFFFF;
            o_dp         <= 6'h00;
            o_digit_vld  <= 6'h00;
            o_sec        <= 6'd0;
            o_min        <= 6'd0;
            o_time_vld   <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
            o_stale      <= 1'b1;
        end else begin
            if (w_cap) begin
                r_tmo <= 32'd0;
            end else if (r_tmo != c_TMO_MAX) begin
                r_tmo <= r_tmo + 32'd1;
            end
            r_sh_dig     <= w_sh_dig_nxt;
            r_sh_dp      <= w_sh_dp_nxt;
            r_sh_vld     <= w_sh_vld_nxt;
            o_frame_done <= w_commit;
            o_err        <= w_err;
            if (w_commit) begin
                o_digits    <= w_sh_dig_nxt;
                o_dp        <= w_sh_dp_nxt;
                o_digit_vld <= w_sh_vld_nxt;
                o_time_vld  <= w_tvld;
                if (w_tvld) begin
                    o_sec <= w_sec;
                    o_min <= w_min;
                end
            end
            if (w_tmo_hit) begin
                o_stale <= 1'b1;
            end else if (w_commit) begin
                o_stale <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
